// File: rtl/laplace_kernel_sequencer.sv
// rtl/laplace_kernel_sequencer.sv - serial 4-neighbour Laplace sequencer driving an external 8-bit adder
module laplace_kernel_sequencer #(
    parameter bit CLAMP_OUT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  center,
    input  logic [7:0]  north,
    input  logic [7:0]  south,
    input  logic [7:0]  east,
    input  logic [7:0]  west,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_s,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADD_N = 3'd1;
    localparam logic [2:0] ADD_S = 3'd2;
    localparam logic [2:0] ADD_E = 3'd3;
    localparam logic [2:0] ADD_W = 3'd4;
    localparam logic [2:0] CALC  = 3'd5;
    localparam logic [2:0] OUT   = 3'd6;

    logic [2:0]  state;
    logic [7:0]  c_q, n_q, s_q, e_q, w_q;
    logic [7:0]  acc_lo;
    logic [2:0]  acc_hi;
    logic [11:0] data_q;

    logic        is_add;
    logic [7:0]  pix;
    logic [11:0] sum12;
    logic [11:0] res;
    logic [11:0] res_final;

    // Select the neighbour fed to the adder in each accumulation step
    always_comb begin
        pix    = 8'd0;
        is_add = 1'b0;
        case (state)
            ADD_N: begin pix = n_q; is_add = 1'b1; end
            ADD_S: begin pix = s_q; is_add = 1'b1; end
            ADD_E: begin pix = e_q; is_add = 1'b1; end
            ADD_W: begin pix = w_q; is_add = 1'b1; end
            default: begin pix = 8'd0; is_add = 1'b0; end
        endcase
    end

    assign add_a     = (is_add && !rst) ? acc_lo : 8'd0;
    assign add_b     = (is_add && !rst) ? pix    : 8'd0;
    assign add_cin   = 1'b0;
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == OUT);
    assign out_data  = data_q;

    // 4*center minus whatever the adder accumulated, optionally clamped to a pixel range
    always_comb begin
        sum12     = {1'b0, acc_hi, acc_lo};
        res       = {2'b00, c_q, 2'b00} - sum12;
        res_final = res;
        if (CLAMP_OUT) begin
            if (res[11])
                res_final = 12'd0;
            else if (res > 12'd255)
                res_final = 12'd255;
            else
                res_final = res;
        end
    end

    // Sequencer state, capture registers and the carry-counting accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            c_q    <= 8'd0;
            n_q    <= 8'd0;
            s_q    <= 8'd0;
            e_q    <= 8'd0;
            w_q    <= 8'd0;
            acc_lo <= 8'd0;
            acc_hi <= 3'd0;
            data_q <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        c_q    <= center;
                        n_q    <= north;
                        s_q    <= south;
                        e_q    <= east;
                        w_q    <= west;
                        acc_lo <= 8'd0;
                        acc_hi <= 3'd0;
                        state  <= ADD_N;
                    end
                end
                ADD_N, ADD_S, ADD_E, ADD_W: begin
                    acc_lo <= add_s;
                    acc_hi <= acc_hi + {2'b00, add_cout};
                    state  <= state + 3'd1;
                end
                CALC: begin
                    data_q <= res_final;
                    state  <= OUT;
                end
                OUT: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_laplace_kernel_sequencer.sv
// tb/tb_laplace_kernel_sequencer.sv - self-checking bench for laplace_kernel_sequencer
module tb_laplace_kernel_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  center = 8'd0, north = 8'd0, south = 8'd0, east = 8'd0, west = 8'd0;

    logic        in_ready0, in_ready1;
    logic [7:0]  add_a0, add_b0, add_s0, add_a1, add_b1, add_s1;
    logic        add_cin0, add_cin1, add_cout0, add_cout1;
    logic        out_valid0, out_valid1;
    logic [11:0] out_data0, out_data1;

    bit          approx = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  adda_seen [4];

    typedef struct {
        logic [7:0]  c, n, s, e, w;
        logic [11:0] exp_raw;
        logic [11:0] exp_clamp;
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    // Adder stand-in: exact, or with the upper nibble approximated (OR, no carry in)
    function automatic logic [8:0] adder_f(input logic [7:0] a, input logic [7:0] b, input bit ap);
        logic [4:0] lo;
        if (!ap)
            return {1'b0, a} + {1'b0, b};
        lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
        return {a[7] & b[7], a[7:4] | b[7:4], lo[3:0]};
    endfunction

    // Reference: accumulate neighbours through the adder function, then 4*center - sum
    function automatic logic [11:0] ref_lap(input logic [7:0] c, input logic [7:0] n, input logic [7:0] s,
                                            input logic [7:0] e, input logic [7:0] w, input bit ap, input bit cl);
        logic [7:0] px [4];
        logic [8:0] r;
        int acc, hi, res;
        px[0] = n; px[1] = s; px[2] = e; px[3] = w;
        acc = 0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            r   = adder_f(acc[7:0], px[i], ap);
            acc = int'(r[7:0]);
            hi  = hi + int'(r[8]);
        end
        res = 4 * int'(c) - (hi * 256 + acc);
        if (cl) begin
            if (res < 0) res = 0;
            else if (res > 255) res = 255;
        end
        return res[11:0];
    endfunction

    always_comb {add_cout0, add_s0} = adder_f(add_a0, add_b0, approx);
    always_comb {add_cout1, add_s1} = adder_f(add_a1, add_b1, approx);

    laplace_kernel_sequencer #(.CLAMP_OUT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .center(center), .north(north), .south(south), .east(east), .west(west),
        .add_a(add_a0), .add_b(add_b0), .add_cin(add_cin0), .add_s(add_s0), .add_cout(add_cout0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
    );

    laplace_kernel_sequencer #(.CLAMP_OUT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .center(center), .north(north), .south(south), .east(east), .west(west),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
    );

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Called at a negedge; presents a window, waits for the result, stalls, then releases it
    task automatic run_window(input logic [7:0] c, input logic [7:0] n, input logic [7:0] s,
                              input logic [7:0] e, input logic [7:0] w,
                              input logic [11:0] e0, input logic [11:0] e1,
                              input int stall, input bit garble);
        int lat, wait_n;
        logic [11:0] d0, d1;
        bit hold_ok, irlow;
        center = c; north = n; south = s; east = e; west = w;
        in_valid = 1'b1;
        wait_n = 0;
        while (!in_ready0 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk("in_ready_before", int'(in_ready0), 1);
        lat = 0;
        irlow = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (garble) begin
                center = 8'($urandom); north = 8'($urandom); south = 8'($urandom);
                east = 8'($urandom); west = 8'($urandom);
                if (in_ready0 || in_ready1) irlow = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            if (lat <= 4) adda_seen[lat-1] = add_a0;
        end while (!out_valid0 && lat < 20);
        chk("latency", lat, 6);
        d0 = out_data0;
        d1 = out_data1;
        chk("out_data_raw", int'(d0), int'(e0));
        chk("out_data_clamp", int'(d1), int'(e1));
        hold_ok = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!out_valid0 || !out_valid1 || out_data0 !== d0 || out_data1 !== d1) hold_ok = 1'b0;
        end
        chk("out_hold", int'(hold_ok), 1);
        if (garble) chk("in_ready_low_busy", int'(irlow), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("out_valid_drop", int'(out_valid0 | out_valid1), 0);
        chk("in_ready_after", int'(in_ready0 & in_ready1), 1);
    endtask

    initial begin
        tbl[0] = '{8'd100, 8'd50,  8'd60,  8'd70,  8'd80,  12'd140,   12'd140};
        tbl[1] = '{8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 12'hC04,   12'd0};
        tbl[2] = '{8'd255, 8'd0,   8'd0,   8'd0,   8'd0,   12'h3FC,   12'd255};
        tbl[3] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12'd0,     12'd0};
        tbl[4] = '{8'd10,  8'd10,  8'd10,  8'd10,  8'd10,  12'd0,     12'd0};
        tbl[5] = '{8'd50,  8'd10,  8'd20,  8'd30,  8'd40,  12'd100,   12'd100};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready0), 0);
        chk("rst_out_valid", int'(out_valid0 | out_valid1), 0);
        chk("rst_out_data", int'(out_data0), 0);
        chk("rst_add_a", int'(add_a0), 0);
        chk("rst_add_b", int'(add_b0), 0);
        chk("rst_add_cin", int'(add_cin0 | add_cin1), 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", int'(in_ready0), 1);
        @(negedge clk);

        // Directed table, exact adder
        approx = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i].c, tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w,
                       tbl[i].exp_raw, tbl[i].exp_clamp, (i == 0) ? 3 : 0, 1'b0);
            if (i == 0) begin
                chk("add_a_n", int'(adda_seen[0]), 0);
                chk("add_a_s", int'(adda_seen[1]), 50);
                chk("add_a_e", int'(adda_seen[2]), 110);
                chk("add_a_w", int'(adda_seen[3]), 180);
            end
        end

        // Inputs wiggling while busy must not disturb the captured window
        run_window(8'd100, 8'd50, 8'd60, 8'd70, 8'd80, 12'd140, 12'd140, 2, 1'b1);

        // Reset during ADD_E aborts the window
        center = 8'd100; north = 8'd50; south = 8'd60; east = 8'd70; west = 8'd80;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_add_a_e", int'(add_a0), 110);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid0 | out_valid1), 0);
        chk("midrst_in_ready", int'(in_ready0), 0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid0 || out_valid1) chk("midrst_no_pulse", 1, 0);
        end
        chk("postrst_in_ready", int'(in_ready0 & in_ready1), 1);
        run_window(8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 12'd0, 12'd0, 0, 1'b0);

        // Approximate adder, random windows back to back with random stalls
        approx = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] c, n, s, e, w;
            int stall;
            c = 8'($urandom); n = 8'($urandom); s = 8'($urandom); e = 8'($urandom); w = 8'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_window(c, n, s, e, w, ref_lap(c, n, s, e, w, 1'b1, 1'b0),
                       ref_lap(c, n, s, e, w, 1'b1, 1'b1), stall, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
